// File: rtl/gsim_sweep_ctrl.sv
// Sweep sequencer for the Gauss-Seidel row-update datapath: issues one row command at a time,
// tracks the per-sweep max |dx|, repeats until convergence or MAX_ITER, then commands readout.
module gsim_sweep_ctrl #(
  parameter int N_UNK    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_ITER = 70
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      tol,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [IDX_W-1:0] row_idx,
  output logic [6:0]       nb_mask,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [31:0]      wb_delta,
  output logic             busy,
  output logic [6:0]       iter_cnt,
  output logic             converged,
  output logic             err,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_READOUT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(N_UNK - 1);
  localparam logic [6:0]       ITER_LIMIT = 7'(MAX_ITER);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] row, row_nxt;
  logic [IDX_W-1:0] out_cnt, out_cnt_nxt;
  logic [31:0]      tol_q, tol_nxt;
  logic [31:0]      max_delta, max_delta_nxt;
  logic [6:0]       iter_q, iter_nxt;
  logic             converged_q, converged_nxt;
  logic             err_q, err_nxt;
  logic             armed_q, armed_nxt;
  logic             done_q, done_nxt;
  logic [6:0]       row_mask;
  logic             wb_match;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      row         <= '0;
      out_cnt     <= '0;
      tol_q       <= '0;
      max_delta   <= '0;
      iter_q      <= '0;
      converged_q <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      out_cnt     <= out_cnt_nxt;
      tol_q       <= tol_nxt;
      max_delta   <= max_delta_nxt;
      iter_q      <= iter_nxt;
      converged_q <= converged_nxt;
      err_q       <= err_nxt;
      armed_q     <= armed_nxt;
      done_q      <= done_nxt;
    end
  end

  // Neighbour k of row r is x[r+k-3]; it exists only inside 0..N_UNK-1.
  always_comb begin
    row_mask = '0;
    for (int k = 0; k < 7; k++) begin
      row_mask[k] = ((int'(row) + k - 3) >= 0) && ((int'(row) + k - 3) < N_UNK);
    end
  end

  assign wb_match = wb_valid && (wb_idx == row);

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    out_cnt_nxt   = out_cnt;
    tol_nxt       = tol_q;
    max_delta_nxt = max_delta;
    iter_nxt      = iter_q;
    converged_nxt = converged_q;
    err_nxt       = err_q;
    armed_nxt     = armed_q;
    done_nxt      = 1'b0;

    // Any write-back other than the one being waited on is a protocol error,
    // but only once a solve has been started since reset.
    if (armed_q && wb_valid && !(state == S_WAIT && wb_match)) begin
      err_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          tol_nxt       = tol;
          iter_nxt      = '0;
          max_delta_nxt = '0;
          converged_nxt = 1'b0;
          err_nxt       = 1'b0;
          armed_nxt     = 1'b1;
          row_nxt       = '0;
          out_cnt_nxt   = '0;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (row_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wb_match) begin
          if (wb_delta > max_delta) max_delta_nxt = wb_delta;
          if (row == LAST_ROW) begin
            state_nxt = S_CHECK;
          end else begin
            row_nxt   = row + 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_CHECK: begin
        iter_nxt = iter_q + 7'd1;
        if (max_delta <= tol_q) begin
          converged_nxt = 1'b1;
          out_cnt_nxt   = '0;
          state_nxt     = S_READOUT;
        end else if ((iter_q + 7'd1) == ITER_LIMIT) begin
          converged_nxt = 1'b0;
          out_cnt_nxt   = '0;
          state_nxt     = S_READOUT;
        end else begin
          max_delta_nxt = '0;
          row_nxt       = '0;
          state_nxt     = S_ISSUE;
        end
      end
      S_READOUT: begin
        out_cnt_nxt = out_cnt + 1'b1;
        if (out_cnt == LAST_ROW) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign row_valid = (state == S_ISSUE);
  assign row_idx   = row_valid ? row : '0;
  assign nb_mask   = row_valid ? row_mask : '0;
  assign busy      = (state != S_IDLE);
  assign iter_cnt  = iter_q;
  assign converged = converged_q;
  assign err       = err_q;
  assign out_valid = (state == S_READOUT);
  assign out_idx   = out_valid ? out_cnt : '0;
  assign done      = done_q;

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Self-checking bench for gsim_sweep_ctrl: a table of solve scenarios driven by a
// behavioural datapath with random stalls/latency and a sweep-level convergence model.
module tb_gsim_sweep_ctrl;

  localparam int N    = 16;
  localparam int IW   = 4;
  localparam int MAXI = 70;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   tol;
  logic          row_valid;
  logic          row_ready;
  logic [IW-1:0] row_idx;
  logic [6:0]    nb_mask;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic [31:0]   wb_delta;
  logic          busy;
  logic [6:0]    iter_cnt;
  logic          converged;
  logic          err;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          done;

  gsim_sweep_ctrl #(.N_UNK(N), .IDX_W(IW), .MAX_ITER(MAXI)) dut (
    .clk(clk), .reset(reset), .start(start), .tol(tol),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx), .nb_mask(nb_mask),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_delta(wb_delta),
    .busy(busy), .iter_cnt(iter_cnt), .converged(converged), .err(err),
    .out_valid(out_valid), .out_idx(out_idx), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // mode 0: constant dval; 1: 100 early then 3; 2: random, shrinking each sweep.
  // inj 1: wrong-index write-back at row 6; inj 2: write-back during ISSUE at row 3.
  typedef struct {
    string       name;
    logic [31:0] tol;
    int          mode;
    logic [31:0] dval;
    bit          stalls;
    int          max_lat;
    int          inj;
    bit          spam;
    int          abort_sweep;
    int          abort_row;
    int          exp_iter;
    int          exp_conv;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_mask(input int r);
    logic [6:0] m;
    m = '0;
    for (int k = 0; k < 7; k++) begin
      if (r + k - 3 >= 0 && r + k - 3 < N) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] delta_for(input vec_t v, input int sweep, input int r);
    int sh;
    case (v.mode)
      0: return v.dval;
      1: begin
        if (sweep == 1) return 32'd100;
        if (sweep == 2 && r == 0) return 32'd100;
        return 32'd3;
      end
      default: begin
        sh = (sweep < 8) ? sweep : 8;
        return 32'($urandom_range(0, 256 >> sh));
      end
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    int          sweep;
    int          n;
    int          lat;
    int          exp_it;
    bit          exp_cv;
    bit          fin;
    logic [31:0] maxd;
    logic [31:0] d;
    sweep  = 0;
    fin    = 1'b0;
    exp_cv = 1'b0;
    tol    = v.tol;
    start  = 1'b1;
    cyc();
    start  = 1'b0;
    check({v.name, ".busy_at_start"}, 32'(busy), 32'd1);
    check({v.name, ".iter_cleared"}, 32'(iter_cnt), 32'd0);
    check({v.name, ".err_cleared"}, 32'(err), 32'd0);
    while (!fin) begin
      maxd = '0;
      for (int r = 0; r < N; r++) begin
        if (v.abort_sweep == sweep && v.abort_row == r) begin
          reset = 1'b1;
          cyc();
          reset = 1'b0;
          check({v.name, ".outputs_after_reset"},
                32'({row_valid, row_idx, nb_mask, busy, iter_cnt, converged, err,
                     out_valid, out_idx, done}), 32'd0);
          wb_valid = 1'b1;
          wb_idx   = IW'(r);
          cyc();
          wb_valid = 1'b0;
          check({v.name, ".late_wb_no_err"}, 32'(err), 32'd0);
          check({v.name, ".idle_after_reset"}, 32'(busy), 32'd0);
          return;
        end
        check({v.name, ".row_valid"}, 32'(row_valid), 32'd1);
        check({v.name, ".row_idx"}, 32'(row_idx), 32'(r));
        check({v.name, ".nb_mask"}, 32'(nb_mask), 32'(exp_mask(r)));
        n = v.stalls ? int'($urandom_range(0, 3)) : 0;
        if (v.inj == 2 && sweep == 0 && r == 3) n = n + 1;
        for (int s = 0; s < n; s++) begin
          row_ready = 1'b0;
          start     = v.spam ? 1'($urandom_range(0, 1)) : 1'b0;
          if (v.inj == 2 && sweep == 0 && r == 3 && s == 0) begin
            wb_valid = 1'b1;
            wb_idx   = IW'(r);
            wb_delta = 32'hFFFF_FFFF;
          end
          cyc();
          wb_valid = 1'b0;
          check({v.name, ".stall_valid"}, 32'(row_valid), 32'd1);
          check({v.name, ".stall_idx"}, 32'(row_idx), 32'(r));
          check({v.name, ".stall_mask"}, 32'(nb_mask), 32'(exp_mask(r)));
        end
        start     = 1'b0;
        row_ready = 1'b1;
        cyc();
        row_ready = 1'b0;
        check({v.name, ".valid_drop"}, 32'(row_valid), 32'd0);
        if (v.inj == 2 && sweep == 0 && r == 3)
          check({v.name, ".err_wb_in_issue"}, 32'(err), 32'd1);
        lat = (v.max_lat > 0) ? int'($urandom_range(0, v.max_lat)) : 0;
        for (int l = 0; l < lat; l++) begin
          start = v.spam ? 1'($urandom_range(0, 1)) : 1'b0;
          cyc();
          check({v.name, ".wait_idle"}, 32'(row_valid), 32'd0);
        end
        start = 1'b0;
        if (v.inj == 1 && sweep == 0 && r == 6) begin
          check({v.name, ".err_before_inject"}, 32'(err), 32'd0);
          wb_valid = 1'b1;
          wb_idx   = IW'(7);
          wb_delta = 32'hFFFF_FFFF;
          cyc();
          wb_valid = 1'b0;
          check({v.name, ".err_wrong_idx"}, 32'(err), 32'd1);
          check({v.name, ".still_waiting"}, 32'(row_valid), 32'd0);
        end
        d = delta_for(v, sweep + 1, r);
        if (d > maxd) maxd = d;
        wb_valid = 1'b1;
        wb_idx   = IW'(r);
        wb_delta = d;
        cyc();
        wb_valid = 1'b0;
      end
      check({v.name, ".check_no_cmd"}, 32'(row_valid | out_valid), 32'd0);
      sweep++;
      if (maxd <= v.tol) begin
        fin    = 1'b1;
        exp_cv = 1'b1;
      end else if (sweep == MAXI) begin
        fin    = 1'b1;
        exp_cv = 1'b0;
      end
      cyc();
    end
    exp_it = sweep;
    if (v.exp_iter >= 0) begin
      exp_it = v.exp_iter;
      exp_cv = (v.exp_conv != 0);
    end
    for (int i = 0; i < N; i++) begin
      check({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
      check({v.name, ".out_idx"}, 32'(out_idx), 32'(i));
      check({v.name, ".done_early"}, 32'(done), 32'd0);
      start = v.spam;
      cyc();
    end
    start = 1'b0;
    check({v.name, ".done"}, 32'(done), 32'd1);
    check({v.name, ".busy_end"}, 32'(busy), 32'd0);
    check({v.name, ".out_valid_end"}, 32'(out_valid), 32'd0);
    check({v.name, ".iter_cnt"}, 32'(iter_cnt), 32'(exp_it));
    check({v.name, ".converged"}, 32'(converged), 32'(exp_cv));
    check({v.name, ".err"}, 32'(err), 32'(v.inj != 0));
    cyc();
    check({v.name, ".done_pulse"}, 32'(done), 32'd0);
    check({v.name, ".iter_hold"}, 32'(iter_cnt), 32'(exp_it));
    check({v.name, ".conv_hold"}, 32'(converged), 32'(exp_cv));
    check({v.name, ".stay_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          name        tol            mode dval  stl lat inj spam abS abR  iter conv
    vecs[0] = '{"basic",    32'hFFFF_FFFF, 0,   5,    0,  0,  0,  0,  -1, -1,  1,   1};
    vecs[1] = '{"maxiter",  32'd0,         0,   1,    0,  0,  0,  0,  -1, -1,  70,  0};
    vecs[2] = '{"conv3",    32'd3,         1,   0,    0,  0,  0,  0,  -1, -1,  3,   1};
    vecs[3] = '{"tol2",     32'd2,         1,   0,    0,  0,  0,  0,  -1, -1,  70,  0};
    vecs[4] = '{"random",   32'd4,         2,   0,    1,  5,  0,  0,  -1, -1,  -1,  0};
    vecs[5] = '{"wrongidx", 32'd1000,      0,   5,    1,  2,  1,  0,  -1, -1,  1,   1};
    vecs[6] = '{"issuewb",  32'd1000,      0,   5,    1,  2,  2,  0,  -1, -1,  1,   1};
    vecs[7] = '{"abort",    32'd0,         0,   1,    0,  1,  0,  0,  1,  9,   -1,  0};

    reset     = 1'b1;
    start     = 1'b0;
    tol       = '0;
    row_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_idx    = '0;
    wb_delta  = '0;
    cyc();
    cyc();
    check("reset_outputs",
          32'({row_valid, row_idx, nb_mask, busy, iter_cnt, converged, err,
               out_valid, out_idx, done}), 32'd0);
    reset = 1'b0;
    wb_valid = 1'b1;
    cyc();
    wb_valid = 1'b0;
    check("unarmed_wb_no_err", 32'(err), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      cyc();
    end

    // Fresh solve after the abort, with start pulsed throughout the busy window.
    run_vec('{"fresh_spam", 32'd50, 2, 0, 1, 3, 0, 1, -1, -1, -1, 0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsim_sweep_ctrl.md
# gsim_sweep_ctrl

Sequencer for the shared Gauss-Seidel row-update datapath of the iterative solver. On `start` it issues row-update commands for rows 0..N_UNK-1, one outstanding at a time, and repeats the sweep until the solution converges or MAX_ITER sweeps complete. It then commands an N_UNK-beat readout of the x memory and pulses `done`. It owns no arithmetic beyond max-delta tracking; the datapath does the theta and divide-by-20 work.

## Interface
- N_UNK, 16, number of unknowns (rows), power of two
- IDX_W, 4, log2(N_UNK)
- MAX_ITER, 70, sweep limit, 1..127
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; clears all state
- start  in  1  begin solve; b already loaded; sampled only in IDLE
- tol  in  32  unsigned convergence threshold on per-sweep max |Δx|, sampled at start
- row_valid  out  1  row-update command valid
- row_ready  in  1  datapath accepts command
- row_idx  out  IDX_W  row being updated
- nb_mask  out  7  bit k set iff neighbour x[row_idx+k-3] is in 0..N_UNK-1
- wb_valid  in  1  datapath write-back complete
- wb_idx  in  IDX_W  row of the write-back
- wb_delta  in  32  unsigned |x_new - x_old| for that row
- busy  out  1  high from the cycle after start is accepted until done
- iter_cnt  out  7  completed sweeps
- converged  out  1  last solve exited on tolerance
- err  out  1  sticky: write-back with wrong index or unexpected write-back
- out_valid  out  1  readout beat valid
- out_idx  out  IDX_W  x memory index for this beat
- done  out  1  one-cycle pulse at end of solve

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, READOUT.
- IDLE: `start`=1 latches tol, clears iter_cnt, max_delta, converged and err, sets row=0, and moves to ISSUE.
- ISSUE: drive row_valid=1 with row_idx=row and nb_mask. On row_valid&row_ready, go to WAIT. row_idx and nb_mask stay stable while row_valid is high and unaccepted.
- WAIT: accept wb_valid only with wb_idx==row. On accept, max_delta = max(max_delta, wb_delta). If row==N_UNK-1, go to CHECK; else row+1 and go to ISSUE. wb_valid with the wrong index sets err and is otherwise ignored.
- wb_valid outside WAIT sets err and is otherwise ignored.
- CHECK: iter_cnt+1.
  - If max_delta<=tol: converged=1, go to READOUT.
  - Else if iter_cnt+1==MAX_ITER: converged=0, go to READOUT.
  - Else clear max_delta, row=0, go to ISSUE.
- READOUT: out_valid=1 for N_UNK consecutive cycles, out_idx 0..N_UNK-1. The cycle after the last beat: done=1, go to IDLE.
- nb_mask: row 0 → 7'b1111000, row 1 → 7'b1111100, row 15 → 7'b0001111, rows 3..12 → 7'b1111111.
- max_delta is a 32-bit unsigned register; the comparison is unsigned and inclusive.
- Row order is strictly ascending. Only one command is outstanding, so the Gauss-Seidel dependency on x[row-1] is always met.
- `start` outside IDLE is ignored.
- iter_cnt, converged and err hold after done until the next accepted start.

## Timing
- Reset values: row_valid=0, row_idx=0, nb_mask=0, busy=0, iter_cnt=0, converged=0, err=0, out_valid=0, out_idx=0, done=0. State is IDLE.
- start sampled at cycle t → busy=1 and row_valid=1 (row 0) at t+1.
- Handshake at cycle t → row_valid=0 at t+1. The same-cycle write-back (wb_valid at t+1 earliest) is legal.
- Write-back accepted at t for row r<N_UNK-1 → row_valid for r+1 at t+1.
- Write-back for row N_UNK-1 at t → CHECK at t+1 → next row_valid or first out_valid at t+2.
- Last out_valid at t → done=1 at t+1, busy=0 at t+1.
- Minimum sweep length is 2·N_UNK+1 cycles with zero datapath latency.
- Reset asserted mid-solve: the next cycle is IDLE with all outputs at reset values. Any write-back still in flight afterwards sets nothing, because err is cleared by reset and only armed after start.
- row_ready held low: the controller stalls in ISSUE indefinitely. There is no timeout.

## Test plan
- Reset, then start with tol=0xFFFFFFFF, a zero-latency datapath and wb_delta=5 → 16 row commands with idx 0..15; iter_cnt=1; converged=1; out_idx 0..15 on 16 consecutive cycles; done exactly 1 cycle after the last beat; first row_valid 1 cycle after start.
- tol=0 and wb_delta=1 for all rows → exactly 70 sweeps (1120 handshakes), iter_cnt=70, converged=0, then readout and done.
- wb_delta=100 in sweeps 1-2 and 3 in sweep 3, tol=3 → exit after sweep 3, iter_cnt=3, converged=1. Repeat with tol=2 → continues to sweep 70.
- Random row_ready stalls and 0-5 cycle write-back latency → row_idx and nb_mask stable while stalled; nb_mask equals 7'b1111000, 7'b1111100, 7'b1111110, 7'b1111111, ..., 7'b0001111 for rows 0..15.
- Inject wb_idx=7 while waiting on row 6, plus a wb_valid during ISSUE → err=1, row 6 still waited on, sweep completes correctly. A second start clears err.
- Assert reset during sweep 2 at row 9 → all outputs 0 next cycle. A fresh start runs a full correct solve. Starts pulsed during busy have no effect.
